ysyx_22040127_exec_ctrl: RTL
============================

Name: ysyx_22040127_exec_ctrl

Overview:
Multi-cycle sequencer for the single-issue RV64 core.
- Steps each instruction through fetch, decode, execute, memory and writeback.
- Holds the instruction register (IR) and the load data register (MDR).
- Generates the PC, register-file and data-memory strobes.
- Sits between the IFU/LSU memory handshakes and the combinational decoder, which reads IR and returns type/flag information.

Parameters:
XLEN, 64, datapath and load-data width
EBREAK_WORD, 32'h00100073, instruction word that signals a good-trap halt

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
imem_req  out  1  instruction fetch request
imem_rvalid  in  1  fetch data valid
imem_rdata  in  32  fetched instruction
ir  out  32  instruction register, feeds the decoder
dec_type  in  3  decoder type: I=0 U=1 S=2 J=3 R=4 B=5 N=6
dec_memread  in  1  decoder: instruction is a load
dec_reg_wen  in  1  decoder: instruction writes rd
dmem_req  out  1  data memory request
dmem_we  out  1  data memory write (store)
dmem_ack  in  1  data memory completion
dmem_rdata  in  XLEN  load data
mdr  out  XLEN  latched load data
pc_wen  out  1  PC update strobe
rf_wen  out  1  register-file write strobe
halted  out  1  core stopped
halt_code  out  1  0 = ebreak, 1 = illegal/unsupported
state  out  3  current FSM state, for debug
cycle_cnt  out  64  performance counter (see Optional Feature)
instret_cnt  out  64  performance counter (see Optional Feature)

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, ir=0, mdr=0, halt_code=0, counters=0. All strobes deassert immediately, including when reset arrives mid-FETCH or mid-MEM.
- Moore FSM. Encoding: IDLE=0 FETCH=1 DECODE=2 EXEC=3 MEM=4 WB=5 HALT=6.
- IDLE: moves to FETCH unconditionally on the next edge.
- FETCH:
  - imem_req=1 for every cycle in FETCH.
  - imem_rvalid is sampled in every FETCH cycle, including the first, so zero-wait memory works.
  - On rvalid: ir<=imem_rdata, go to DECODE. Otherwise stay in FETCH.
- DECODE: one cycle; decoder outputs settle from ir. Go to EXEC.
- EXEC, one cycle; first matching rule wins:
  - ir==EBREAK_WORD → HALT, halt_code=0.
  - dec_type==N (non-ebreak) or dec_type==7 → HALT, halt_code=1.
  - dec_memread=1 or dec_type==S → MEM.
  - Otherwise → WB.
- MEM:
  - dmem_req=1; dmem_we=1 iff dec_type==S.
  - Wait for dmem_ack. On ack: if a load, mdr<=dmem_rdata; go to WB.
  - No timeout.
- WB:
  - pc_wen=1 for exactly one cycle.
  - rf_wen = dec_reg_wen (0 for S and B).
  - Go to FETCH.
- HALT:
  - halted=1; sticky until reset.
  - All other strobes 0; imem_rvalid and dmem_ack are ignored.
- imem_rvalid outside FETCH and dmem_ack outside MEM are ignored (no state change, no register update).
- Cycle count per instruction, for 0-wait memories:
  - ALU/branch/jump: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Load/store: 5 cycles.
- ir and mdr hold their values between updates.

Optional Feature:
Macro: YSYX_22040127_PERF_CNT_EN
- Defined:
  - cycle_cnt increments every cycle where state≠HALT and state≠IDLE.
  - instret_cnt increments each WB cycle.
  - Both wrap modulo 2^64.
- Undefined: both ports are still present and are tied to 0.

Decomposition:
- Shared package `ysyx_22040127_pkg` holds:
  - type localparams TYPE_I..TYPE_N;
  - FSM state encodings;
  - EBREAK_WORD default.
- The decoder already lives separately. No sub-module is needed; the FSM and registers stay in one module.

Test Plan:
- Reset then ir fed 32'h00500093 (addi) with 0-wait imem → states 1,2,3,5. pc_wen=1 and rf_wen=1 in cycle 4 only; back to FETCH.
- Load 32'h0000b103 with dmem_ack delayed 3 cycles → dmem_req high 4 cycles with dmem_we=0; mdr=dmem_rdata (e.g. 64'hDEADBEEF_CAFEF00D) in WB; rf_wen=1.
- Store 32'h0020b023 → dmem_we=1 in MEM; WB has pc_wen=1 and rf_wen=0. Then branch 32'h00208463 → no MEM, rf_wen=0.
- 32'h00100073 → HALT, halted=1, halt_code=0. Then 32'h00000073 (ecall) after a reset → halt_code=1. Spurious rvalid and ack pulses in HALT cause no change.
- rst driven low mid-MEM (asynchronously, between edges) → dmem_req drops in the same cycle, state=0; after release, IDLE→FETCH.
- With PERF_CNT_EN: 10 addi then ebreak with 0-wait memory → instret_cnt=10, cycle_cnt=43. Without the macro: both read 0.

Source files
------------

// File: rtl/ysyx_22040127_pkg.sv
// Shared types and constants for the ysyx_22040127 multi-cycle core sequencer.
package ysyx_22040127_pkg;

   localparam int unsigned XLEN_DEF        = 64;
   localparam logic [31:0] EBREAK_WORD_DEF = 32'h00100073;

   localparam logic [2:0] TYPE_I = 3'd0;
   localparam logic [2:0] TYPE_U = 3'd1;
   localparam logic [2:0] TYPE_S = 3'd2;
   localparam logic [2:0] TYPE_J = 3'd3;
   localparam logic [2:0] TYPE_R = 3'd4;
   localparam logic [2:0] TYPE_B = 3'd5;
   localparam logic [2:0] TYPE_N = 3'd6;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_MEM    = 3'd4,
      ST_WB     = 3'd5,
      ST_HALT   = 3'd6
   } state_e;

   // Strobe bundle driven by the sequencer, one bit per downstream unit.
   typedef struct packed {
      logic imem_req;
      logic dmem_req;
      logic dmem_we;
      logic pc_wen;
      logic rf_wen;
      logic halted;
   } strobes_t;

   // Type 7 is unassigned by the decoder and is treated like N.
   function automatic logic is_unsupported(input logic [2:0] t);
      return (t == TYPE_N) || (t == 3'd7);
   endfunction

endpackage

// File: rtl/ysyx_22040127_exec_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer holding IR and MDR.
// Performance counters are built only when YSYX_22040127_PERF_CNT_EN is defined.
module ysyx_22040127_exec_ctrl
   import ysyx_22040127_pkg::*;
#(
   parameter int unsigned XLEN        = XLEN_DEF,
   parameter logic [31:0] EBREAK_WORD = EBREAK_WORD_DEF
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req,
   input  logic            imem_rvalid,
   input  logic [31:0]     imem_rdata,
   output logic [31:0]     ir,
   input  logic [2:0]      dec_type,
   input  logic            dec_memread,
   input  logic            dec_reg_wen,
   output logic            dmem_req,
   output logic            dmem_we,
   input  logic            dmem_ack,
   input  logic [XLEN-1:0] dmem_rdata,
   output logic [XLEN-1:0] mdr,
   output logic            pc_wen,
   output logic            rf_wen,
   output logic            halted,
   output logic            halt_code,
   output logic [2:0]      state,
   output logic [63:0]     cycle_cnt,
   output logic [63:0]     instret_cnt
);

   state_e          r_state;
   strobes_t        r_strb;
   logic [31:0]     r_ir;
   logic [XLEN-1:0] r_mdr;
   logic            r_halt_code;
   logic            w_rd_write;

   // S and B never write rd, even if the decoder says otherwise.
   assign w_rd_write = dec_reg_wen && (dec_type != TYPE_S) && (dec_type != TYPE_B);

   // Strobes are registered alongside the state so they track it cycle for cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= ST_IDLE;
         r_strb      <= '0;
         r_ir        <= '0;
         r_mdr       <= '0;
         r_halt_code <= 1'b0;
      end else begin
         r_strb <= '0;
         case (r_state)
            ST_IDLE: begin
               r_state         <= ST_FETCH;
               r_strb.imem_req <= 1'b1;
            end
            ST_FETCH: begin
               if (imem_rvalid) begin
                  r_ir    <= imem_rdata;
                  r_state <= ST_DECODE;
               end else begin
                  r_strb.imem_req <= 1'b1;
               end
            end
            ST_DECODE: r_state <= ST_EXEC;
            ST_EXEC: begin
               if (r_ir == EBREAK_WORD) begin
                  r_state       <= ST_HALT;
                  r_strb.halted <= 1'b1;
                  r_halt_code   <= 1'b0;
               end else if (is_unsupported(dec_type)) begin
                  r_state       <= ST_HALT;
                  r_strb.halted <= 1'b1;
                  r_halt_code   <= 1'b1;
               end else if (dec_memread || (dec_type == TYPE_S)) begin
                  r_state         <= ST_MEM;
                  r_strb.dmem_req <= 1'b1;
                  r_strb.dmem_we  <= (dec_type == TYPE_S);
               end else begin
                  r_state       <= ST_WB;
                  r_strb.pc_wen <= 1'b1;
                  r_strb.rf_wen <= w_rd_write;
               end
            end
            ST_MEM: begin
               if (dmem_ack) begin
                  if (dec_memread) r_mdr <= dmem_rdata;
                  r_state       <= ST_WB;
                  r_strb.pc_wen <= 1'b1;
                  r_strb.rf_wen <= w_rd_write;
               end else begin
                  r_strb.dmem_req <= 1'b1;
                  r_strb.dmem_we  <= (dec_type == TYPE_S);
               end
            end
            ST_WB: begin
               r_state         <= ST_FETCH;
               r_strb.imem_req <= 1'b1;
            end
            ST_HALT: r_strb.halted <= 1'b1;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign state     = r_state;
   assign ir        = r_ir;
   assign mdr       = r_mdr;
   assign halt_code = r_halt_code;
   assign imem_req  = r_strb.imem_req;
   assign dmem_req  = r_strb.dmem_req;
   assign dmem_we   = r_strb.dmem_we;
   assign pc_wen    = r_strb.pc_wen;
   assign rf_wen    = r_strb.rf_wen;
   assign halted    = r_strb.halted;

`ifdef YSYX_22040127_PERF_CNT_EN
   logic [63:0] r_cycle_cnt;
   logic [63:0] r_instret_cnt;

   // Active cycles exclude IDLE and HALT; retirement is marked by WB.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cycle_cnt   <= '0;
         r_instret_cnt <= '0;
      end else begin
         if ((r_state != ST_HALT) && (r_state != ST_IDLE)) r_cycle_cnt <= r_cycle_cnt + 64'd1;
         if (r_state == ST_WB) r_instret_cnt <= r_instret_cnt + 64'd1;
      end
   end

   assign cycle_cnt   = r_cycle_cnt;
   assign instret_cnt = r_instret_cnt;
`else
   assign cycle_cnt   = '0;
   assign instret_cnt = '0;
`endif

endmodule
